// File: rtl/data_mem_if.sv
// Request/response bus between the processor datapath (master) and the
// data memory controller (slave).
interface data_mem_if;
  logic       req_valid;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] addr;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic       ack;
  logic       busy;
  logic       err;

  modport master (
    output req_valid, mem_read, mem_write, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req_valid, mem_read, mem_write, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// 16 x 4-bit data memory with a wait-state controller: one request at a time,
// WAIT_CYCLES wait states, then a single ACCESS cycle that pulses ack.
module data_mem_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t     state, state_d;
  logic [2:0] wait_cnt;
  logic [3:0] addr_q;
  logic [3:0] wdata_q;
  logic       write_q;
  logic [3:0] rdata_q;
  logic       err_q;
  logic [3:0] mem [16];

  logic       legal_req;
  logic       illegal_req;
  logic       accept;
  logic       enter_access;
  logic [3:0] acc_addr;
  logic [3:0] acc_wdata;
  logic       acc_write;

  assign legal_req   = bus.req_valid && (bus.mem_read ^ bus.mem_write);
  assign illegal_req = bus.req_valid && bus.mem_read && bus.mem_write;
  assign accept      = (state == IDLE) && legal_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (legal_req) state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt <= 3'd1) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero-wait access enters ACCESS on the acceptance edge itself, so its
  // operands must come straight off the bus rather than from the capture regs.
  always_comb begin
    enter_access = (state_d == ACCESS);
    if (state == IDLE) begin
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_write = bus.mem_write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = write_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      err_q <= (state == IDLE) && illegal_req;
      if (accept) begin
        addr_q   <= bus.addr;
        wdata_q  <= bus.wdata;
        write_q  <= bus.mem_write;
        wait_cnt <= 3'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
      end else if (state == ACCESS) begin
        wait_cnt <= '0;
      end
      if (enter_access) begin
        if (acc_write) mem[acc_addr] <= acc_wdata;
        else           rdata_q       <= mem[acc_addr];
      end
    end
  end

  always_comb begin
    bus.ack   = (state == ACCESS);
    bus.busy  = (state == WAIT);
    bus.err   = err_q;
    bus.rdata = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a WAIT_CYCLES=2 instance driven from a
// vector table plus corner sequences, and a WAIT_CYCLES=0 instance.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus2();
  data_mem_if bus0();

  data_mem_ctrl #(.WAIT_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic v, input logic rd, input logic wr,
                        input logic [3:0] a, input logic [3:0] d);
    bus2.req_valid = v;
    bus2.mem_read  = rd;
    bus2.mem_write = wr;
    bus2.addr      = a;
    bus2.wdata     = d;
  endtask

  // Presents one request for a single cycle, scrambles the bus after acceptance,
  // then waits (bounded) for ack and checks timing, busy and rdata.
  task automatic run_op2(input vec_t v);
    int lat;
    drive2(1'b1, v.rd, v.wr, v.addr, v.wdata);
    step();
    chk("busy_after_accept", 32'(bus2.busy), 1);
    drive2(1'b0, 1'b0, 1'b0, ~v.addr, ~v.wdata);
    lat = 1;
    while (!bus2.ack && lat < 20) begin
      step();
      lat++;
    end
    chk("ack_latency", lat, 3);
    chk("busy_in_ack", 32'(bus2.busy), 0);
    chk("rdata", 32'(bus2.rdata), 32'(v.exp_rdata));
    step();
    chk("ack_pulse_width", 32'(bus2.ack), 0);
  endtask

  initial begin
    int acks;
    int err_seen;
    vecs[0] = '{1'b0, 1'b1, 4'h3, 4'hA, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 4'h3, 4'h0, 4'hA};
    vecs[2] = '{1'b0, 1'b1, 4'h0, 4'h5, 4'hA};
    vecs[3] = '{1'b0, 1'b1, 4'hF, 4'h9, 4'hA};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h5};
    vecs[5] = '{1'b1, 1'b0, 4'h7, 4'h0, 4'h0};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'h9};
    vecs[7] = '{1'b0, 1'b1, 4'h7, 4'h6, 4'h9};
    vecs[8] = '{1'b1, 1'b0, 4'h7, 4'h0, 4'h6};
    vecs[9] = '{1'b1, 1'b0, 4'h3, 4'h0, 4'hA};

    drive2(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    bus0.req_valid = 1'b0;
    bus0.mem_read  = 1'b0;
    bus0.mem_write = 1'b0;
    bus0.addr      = 4'h0;
    bus0.wdata     = 4'h0;

    // Reset state
    step();
    step();
    chk("rst_ack", 32'(bus2.ack), 0);
    chk("rst_busy", 32'(bus2.busy), 0);
    chk("rst_err", 32'(bus2.err), 0);
    chk("rst_rdata", 32'(bus2.rdata), 0);
    chk("rst_ack_w0", 32'(bus0.ack), 0);
    rst_n = 1'b1;

    // Table: first request goes in on the very first edge after reset release
    for (int i = 0; i < 10; i++) run_op2(vecs[i]);

    // Illegal request: err pulse only
    drive2(1'b1, 1'b1, 1'b1, 4'h3, 4'h0);
    step();
    chk("illegal_err", 32'(bus2.err), 1);
    chk("illegal_busy", 32'(bus2.busy), 0);
    chk("illegal_ack", 32'(bus2.ack), 0);
    drive2(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    chk("illegal_err_width", 32'(bus2.err), 0);
    chk("illegal_state_idle", 32'(bus2.busy), 0);
    run_op2('{1'b1, 1'b0, 4'h3, 4'h0, 4'hA});

    // Request while busy is dropped, not queued
    drive2(1'b1, 1'b0, 1'b1, 4'h5, 4'hC);
    step();
    chk("busy_seq_busy", 32'(bus2.busy), 1);
    drive2(1'b1, 1'b0, 1'b1, 4'h6, 4'hD);
    step();
    drive2(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    acks = 0;
    err_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus2.ack) acks++;
      if (bus2.err) err_seen++;
    end
    chk("busy_seq_ack_count", acks, 1);
    chk("busy_seq_err", err_seen, 0);
    run_op2('{1'b1, 1'b0, 4'h6, 4'h0, 4'h0});
    run_op2('{1'b1, 1'b0, 4'h5, 4'h0, 4'hC});

    // Reset during WAIT aborts the write and clears the array
    drive2(1'b1, 1'b0, 1'b1, 4'h2, 4'hF);
    step();
    chk("abort_busy", 32'(bus2.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_async_busy", 32'(bus2.busy), 0);
    chk("abort_async_rdata", 32'(bus2.rdata), 0);
    drive2(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus2.ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    run_op2('{1'b1, 1'b0, 4'h2, 4'h0, 4'h0});
    run_op2('{1'b1, 1'b0, 4'h3, 4'h0, 4'h0});

    // WAIT_CYCLES=0, held requests: ack right after acceptance, one access per 2 cycles
    bus0.req_valid = 1'b1;
    bus0.mem_write = 1'b1;
    bus0.addr      = 4'h4;
    bus0.wdata     = 4'hB;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("w0_ack_pattern", 32'(bus0.ack), ((k % 2) == 0) ? 1 : 0);
      chk("w0_busy", 32'(bus0.busy), 0);
    end
    bus0.mem_write = 1'b0;
    bus0.mem_read  = 1'b1;
    step();
    chk("w0_read_ack", 32'(bus0.ack), 1);
    chk("w0_read_rdata", 32'(bus0.rdata), 4'hB);
    bus0.req_valid = 1'b0;
    bus0.mem_read  = 1'b0;
    step();
    chk("w0_ack_drop", 32'(bus0.ack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access; legal range 0..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  request strobe from the processor datapath.
REQ-005 mem_read  input  1  read request, qualified by req_valid.
REQ-006 mem_write  input  1  write request, qualified by req_valid.
REQ-007 addr  input  4  word address, 16 locations.
REQ-008 wdata  input  4  write data.
REQ-009 rdata  output  4  read data, registered.
REQ-010 ack  output  1  one-cycle completion pulse for read or write.
REQ-011 busy  output  1  high from acceptance until the ack cycle, exclusive.
REQ-012 err  output  1  one-cycle pulse on an illegal request.

Function
REQ-013 The block SHALL hold a 16 x 4-bit storage array, responder to the mem_read/mem_write strobes issued by the control unit.
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, ACCESS; encoding is free.
REQ-015 In IDLE, req_valid=1 with exactly one of mem_read/mem_write SHALL be accepted at that edge: addr, wdata and op captured, busy=1 from the next cycle.
REQ-016 An accepted request SHALL go to WAIT with a wait counter loaded to WAIT_CYCLES, or directly to ACCESS when WAIT_CYCLES=0.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, then go to ACCESS.
REQ-018 ACCESS SHALL last one cycle: a write updates the array at the entry edge; a read loads rdata at the entry edge; ack=1 and busy=0 during that cycle; next state IDLE.
REQ-019 Latency: ack SHALL be high in the cycle beginning WAIT_CYCLES+1 edges after the acceptance edge.
REQ-020 Captured addr/wdata SHALL be used; input changes after acceptance SHALL have no effect.
REQ-021 req_valid while busy=1 SHALL be ignored: no queueing, no err, no state change.
REQ-022 A request present during the ack cycle SHALL NOT be accepted in that cycle; it is accepted at the following edge if still present in IDLE. Maximum throughput is one access per WAIT_CYCLES+2 cycles.
REQ-023 req_valid=1 with both mem_read and mem_write high in IDLE SHALL pulse err for one cycle, perform no access, and remain in IDLE.
REQ-024 req_valid=1 with neither strobe high SHALL be ignored.
REQ-025 rdata SHALL hold its last read value until the next read's ACCESS cycle; writes SHALL NOT change rdata.
REQ-026 A read following a write to the same address SHALL return the written value.
REQ-027 The address SHALL be a full 4-bit index with no wrap or aliasing; all 16 locations are distinct.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, wait counter 0, rdata=0, ack=0, busy=0, err=0, and all array locations to 0.
REQ-029 Reset during WAIT or ACCESS SHALL abort the request with no ack, and the array SHALL read all zeros afterwards.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-031 Write addr=4'h3, wdata=4'hA, then read addr=3 -> each ack exactly 3 cycles after its acceptance edge (WAIT_CYCLES=2); rdata=4'hA.
REQ-032 Write 4'h5 to addr 0 and 4'h9 to addr 15, then read both -> 4'h5 and 4'h9; reading addr 7 returns 4'h0.
REQ-033 req_valid with mem_read=mem_write=1 -> one-cycle err pulse, no ack, busy stays 0, array unchanged.
REQ-034 Second request asserted while busy, dropped before ack -> no second ack, array unchanged by it.
REQ-035 Assert rst_n=0 during WAIT of a write of 4'hF to addr 2 -> no ack; a later read of addr 2 returns 4'h0.
REQ-036 WAIT_CYCLES=0 with back-to-back held requests -> ack one cycle after acceptance; accesses every 2 cycles.
